// File: rtl/scancode_tone_pkg.sv
// scancode_tone_pkg: scancode constants, key map, note increments, envelope states and wave modes
package scancode_tone_pkg;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [1:0] MODE_SQUARE = 2'd0;
  localparam logic [1:0] MODE_SAW = 2'd1;
  localparam logic [1:0] MODE_TRI = 2'd2;
  localparam logic [1:0] MODE_MUTE = 2'd3;
  typedef enum logic [1:0] {ENV_IDLE, ENV_ATTACK, ENV_SUSTAIN, ENV_RELEASE} env_state_t;
  function automatic logic [3:0] key_lookup(input logic [7:0] code);
    case (code)
      8'h1C: return 4'b1000;
      8'h1B: return 4'b1001;
      8'h23: return 4'b1010;
      8'h2B: return 4'b1011;
      8'h34: return 4'b1100;
      8'h33: return 4'b1101;
      8'h3B: return 4'b1110;
      8'h42: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction
  function automatic logic [23:0] note_inc(input logic [2:0] idx);
    case (idx)
      3'd0: return 24'd91447;
      3'd1: return 24'd102647;
      3'd2: return 24'd115214;
      3'd3: return 24'd122065;
      3'd4: return 24'd137013;
      3'd5: return 24'd153791;
      3'd6: return 24'd172625;
      default: return 24'd182894;
    endcase
  endfunction
endpackage

// File: rtl/scancode_tone_synth_envelope.sv
// tone_envelope: linear attack/release envelope FSM with saturating amplitude register
module tone_envelope
  import scancode_tone_pkg::*;
#(
  parameter int AMP_W = 8,
  parameter int ATTACK_STEP = 4,
  parameter int RELEASE_STEP = 2
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             sample_tick,
  input  logic             make_evt,
  input  logic             same_key,
  input  logic             brk_evt,
  output logic [AMP_W-1:0] amp,
  output env_state_t       state
);
  localparam logic [AMP_W-1:0] AMP_MAX = '1;
  env_state_t state_q, state_d, st_p;
  logic [AMP_W-1:0] amp_q, amp_d, up_sat, dn_sat;
  logic [AMP_W:0] amp_up;
  always_comb begin
    st_p = make_evt ? ((same_key && (state_q == ENV_ATTACK || state_q == ENV_SUSTAIN)) ? state_q : ENV_ATTACK)
         : (brk_evt && (state_q == ENV_ATTACK || state_q == ENV_SUSTAIN)) ? ENV_RELEASE : state_q;
    amp_up = {1'b0, amp_q} + (AMP_W+1)'(ATTACK_STEP);
    up_sat = amp_up > {1'b0, AMP_MAX} ? AMP_MAX : amp_up[AMP_W-1:0];
    dn_sat = amp_q > AMP_W'(RELEASE_STEP) ? amp_q - AMP_W'(RELEASE_STEP) : '0;
    amp_d = !sample_tick ? amp_q
          : st_p == ENV_ATTACK ? up_sat
          : st_p == ENV_RELEASE ? dn_sat
          : st_p == ENV_IDLE ? '0 : amp_q;
    state_d = !sample_tick ? st_p
            : (st_p == ENV_ATTACK && up_sat == AMP_MAX) ? ENV_SUSTAIN
            : (st_p == ENV_RELEASE && dn_sat == '0) ? ENV_IDLE : st_p;
  end
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= ENV_IDLE;
      amp_q <= '0;
    end else begin
      state_q <= state_d;
      amp_q <= amp_d;
    end
  end
  assign amp = amp_q;
  assign state = state_q;
endmodule

// File: rtl/scancode_tone_synth.sv
// scancode_tone_synth: PS/2 scancode parser driving a phase-accumulator tone with waveform select and envelope
module scancode_tone_synth
  import scancode_tone_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int PHASE_W = 24,
  parameter int AMP_W = 8,
  parameter int ATTACK_STEP = 4,
  parameter int RELEASE_STEP = 2
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [7:0]                 scancode,
  input  logic                       scancode_valid,
  input  logic                       sample_tick,
  input  logic [1:0]                 mode,
  input  logic                       go,
  output logic signed [SAMPLE_W-1:0] sound,
  output logic                       sound_valid,
  output logic                       note_active,
  output logic [2:0]                 note_index
);
  localparam int PW = SAMPLE_W + AMP_W + 1;
  localparam logic [SAMPLE_W-1:0] SQ_HI = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [SAMPLE_W-1:0] SQ_LO = {1'b1, {(SAMPLE_W-2){1'b0}}, 1'b1};
  logic brk_q, brk_d, ext_q, ext_d, valid_q, byte_evt, make_evt, brk_evt;
  logic [2:0] note_q, note_d;
  logic [3:0] hit;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [SAMPLE_W-1:0] p;
  logic [SAMPLE_W-2:0] fold;
  logic signed [SAMPLE_W-1:0] wave, sound_q, sound_d;
  logic signed [PW-1:0] prod;
  logic [AMP_W-1:0] amp;
  env_state_t env;
  always_comb begin
    hit = key_lookup(scancode);
    brk_d = !scancode_valid ? brk_q : scancode == SC_BREAK ? 1'b1 : scancode == SC_EXT ? brk_q : 1'b0;
    ext_d = !scancode_valid ? ext_q : scancode == SC_EXT ? 1'b1 : scancode == SC_BREAK ? ext_q : 1'b0;
    byte_evt = scancode_valid && scancode != SC_BREAK && scancode != SC_EXT && !ext_q && hit[3];
    make_evt = byte_evt && !brk_q;
    brk_evt = byte_evt && brk_q && hit[2:0] == note_q;
    note_d = make_evt ? hit[2:0] : note_q;
    phase_d = sample_tick ? phase_q + PHASE_W'(note_inc(note_q)) : phase_q;
    p = phase_q[PHASE_W-1 -: SAMPLE_W];
    fold = p[SAMPLE_W-1] ? ~p[SAMPLE_W-2:0] : p[SAMPLE_W-2:0];
    wave = mode == MODE_SQUARE ? (phase_q[PHASE_W-1] ? SQ_LO : SQ_HI)
         : mode == MODE_SAW ? {~p[SAMPLE_W-1], p[SAMPLE_W-2:0]}
         : mode == MODE_TRI ? {~fold[SAMPLE_W-2], fold[SAMPLE_W-3:0], 1'b0} : '0;
    prod = PW'(wave) * PW'($signed({1'b0, amp}));
    sound_d = !sample_tick ? sound_q : go ? SAMPLE_W'(prod >>> AMP_W) : '0;
  end
  tone_envelope #(
    .AMP_W(AMP_W),
    .ATTACK_STEP(ATTACK_STEP),
    .RELEASE_STEP(RELEASE_STEP)
  ) u_env (
    .clock(clock),
    .resetn(resetn),
    .sample_tick(sample_tick),
    .make_evt(make_evt),
    .same_key(hit[2:0] == note_q),
    .brk_evt(brk_evt),
    .amp(amp),
    .state(env)
  );
  always_ff @(posedge clock) begin
    if (!resetn) begin
      brk_q <= 1'b0;
      ext_q <= 1'b0;
      note_q <= '0;
      phase_q <= '0;
      sound_q <= '0;
      valid_q <= 1'b0;
    end else begin
      brk_q <= brk_d;
      ext_q <= ext_d;
      note_q <= note_d;
      phase_q <= phase_d;
      sound_q <= sound_d;
      valid_q <= sample_tick;
    end
  end
  assign sound = sound_q;
  assign sound_valid = valid_q;
  assign note_active = env != ENV_IDLE;
  assign note_index = note_q;
endmodule

// File: tb/tb_scancode_tone_synth.sv
// tb_scancode_tone_synth: directed and random stimulus checked against a behavioural synth model
module tb_scancode_tone_synth;
  logic clock = 0, resetn = 0, scancode_valid = 0, sample_tick = 0, go = 0;
  logic [7:0] scancode = 0;
  logic [1:0] mode = 0;
  logic signed [15:0] sound;
  logic sound_valid, note_active;
  logic [2:0] note_index;
  int total = 0, bad = 0;
  int m_phase, m_amp, m_env, m_note, m_sound, m_valid, m_brk, m_ext;
  int inc_tab [8] = '{91447, 102647, 115214, 122065, 137013, 153791, 172625, 182894};
  int keys [8] = '{'h1C, 'h1B, 'h23, 'h2B, 'h34, 'h33, 'h3B, 'h42};
  scancode_tone_synth dut (
    .clock(clock),
    .resetn(resetn),
    .scancode(scancode),
    .scancode_valid(scancode_valid),
    .sample_tick(sample_tick),
    .mode(mode),
    .go(go),
    .sound(sound),
    .sound_valid(sound_valid),
    .note_active(note_active),
    .note_index(note_index)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int key_of(input int c);
    for (int i = 0; i < 8; i++) if (keys[i] == c) return i;
    return -1;
  endfunction
  function automatic int sample_of(input int ph, input int amp, input int md);
    int pp, f, w;
    longint prod;
    pp = ph >> 8;
    f = pp < 32768 ? pp : 65535 - pp;
    w = md == 0 ? (ph >= (1 << 23) ? -32767 : 32767) : md == 1 ? pp - 32768 : md == 2 ? 2 * f - 32768 : 0;
    prod = longint'(w) * amp;
    return int'(prod >>> 8);
  endfunction
  task automatic model_edge();
    int old, k;
    bit held;
    if (!resetn) begin
      {m_phase, m_amp, m_env, m_note, m_sound, m_valid, m_brk, m_ext} = '0;
      return;
    end
    old = m_note;
    m_valid = sample_tick;
    if (sample_tick) m_sound = go ? sample_of(m_phase, m_amp, mode) : 0;
    if (scancode_valid) begin
      if (scancode == 8'hF0) m_brk = 1;
      else if (scancode == 8'hE0) m_ext = 1;
      else begin
        k = key_of(scancode);
        held = (m_env == 1 || m_env == 2);
        if (!m_ext && k >= 0) begin
          if (!m_brk) begin
            if (!(k == m_note && held)) m_env = 1;
            m_note = k;
          end else if (k == m_note && held) m_env = 3;
        end
        m_brk = 0;
        m_ext = 0;
      end
    end
    if (sample_tick) begin
      if (m_env == 1) begin
        m_amp = m_amp + 4 > 255 ? 255 : m_amp + 4;
        if (m_amp == 255) m_env = 2;
      end else if (m_env == 3) begin
        m_amp = m_amp - 2 < 0 ? 0 : m_amp - 2;
        if (m_amp == 0) m_env = 0;
      end else if (m_env == 0) m_amp = 0;
      m_phase = (m_phase + inc_tab[old]) % (1 << 24);
    end
  endtask
  task automatic step(input logic [7:0] sc, input logic v, input logic t);
    scancode = sc;
    scancode_valid = v;
    sample_tick = t;
    @(posedge clock);
    #1;
    model_edge();
    chk("sound_valid", int'(sound_valid), m_valid);
    chk("sound", int'(sound), m_sound);
    chk("note_active", int'(note_active), int'(m_env != 0));
    chk("note_index", int'(note_index), m_note);
    scancode_valid = 0;
    sample_tick = 0;
  endtask
  task automatic send(input logic [7:0] c);
    step(c, 1, 0);
  endtask
  task automatic tick_n(input int n);
    repeat (n) begin
      step(0, 0, 1);
      step(0, 0, 0);
    end
  endtask
  initial begin
    int r;
    resetn = 0;
    step(0, 0, 0);
    step(0, 0, 0);
    chk("rst_sound", int'(sound), 0);
    chk("rst_active", int'(note_active), 0);
    resetn = 1;
    mode = 0;
    go = 1;
    send(8'h1C);
    tick_n(65);
    chk("sustain_mag", sound < 0 ? -int'(sound) : int'(sound), 32639);
    mode = 1;
    tick_n(6);
    mode = 2;
    tick_n(6);
    mode = 0;
    send(8'h33);
    tick_n(3);
    chk("legato_note", int'(note_index), 5);
    send(8'hF0);
    send(8'h1C);
    tick_n(2);
    chk("foreign_break", int'(note_active), 1);
    send(8'hF0);
    send(8'h33);
    tick_n(128);
    chk("release_done", int'(note_active), 0);
    send(8'hE0);
    send(8'h1C);
    tick_n(1);
    send(8'h99);
    send(8'hF0);
    send(8'h1B);
    tick_n(1);
    chk("prefix_none", int'(note_active), 0);
    send(8'h1B);
    chk("flags_clear", int'(note_active), 1);
    send(8'hF0);
    send(8'h1B);
    tick_n(130);
    step(8'h1C, 1, 1);
    chk("simul_sound", int'(sound), 0);
    tick_n(2);
    mode = 3;
    go = 0;
    tick_n(4);
    go = 1;
    mode = 0;
    tick_n(4);
    tick_n(70);
    resetn = 0;
    repeat (3) step(0, 0, 1);
    resetn = 1;
    chk("midrst_active", int'(note_active), 0);
    chk("midrst_sound", int'(sound), 0);
    send(8'hF0);
    send(8'h1C);
    tick_n(2);
    chk("midrst_nonote", int'(note_active), 0);
    for (int i = 0; i < 4000; i++) begin
      resetn = $urandom_range(0, 399) != 0;
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) go = ~go;
      r = $urandom_range(0, 9);
      scancode = r == 0 ? 8'hF0 : r == 1 ? 8'hE0 : r == 2 ? 8'($urandom_range(0, 255)) : 8'(keys[$urandom_range(0, 7)]);
      step(scancode, $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
